// File: rtl/instr_prefetch_queue_pkg.sv
// Constants and entry layout shared by the prefetch queue, the core and the memory models.
package instr_prefetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          WORD_W           = 32;
    localparam int          ENTRY_W          = 2 * WORD_W;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; flush empties it in one cycle.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: issues sequential word fetches, buffers in-order responses and
// hands them to the core; a redirect flushes the queue and discards in-flight responses.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int OW  = $clog2(2 * DEPTH);
    localparam int OW1 = OW + 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          run_q;

    logic [OW-1:0] live;
    logic [OW:0]   occupancy;
    logic          accept, resp_keep, pop;

    entry_t        q_head, q_push;
    logic          q_empty, q_full;
    logic [CW-1:0] q_count;
    logic [31:0]   req_pc;
    logic          pc_empty, pc_full;
    logic [CW-1:0] pc_count;

    // Live requests plus buffered words must fit the queue so every kept response has a slot.
    assign live      = outstanding_q - discard_q;
    assign occupancy = OW1'(q_count) + OW1'(live);
    assign mem_req   = run_q & ~redirect & (occupancy < OW1'(DEPTH))
                     & (outstanding_q < OW'(2 * DEPTH - 1));
    assign mem_addr  = fetch_pc_q;
    assign accept    = mem_req & mem_ready;
    assign resp_keep = mem_rvalid & ~redirect & (discard_q == '0);
    assign pop       = ins_valid & ins_ready & ~redirect;

    assign q_push.word = mem_rdata;
    assign q_push.pc   = req_pc;
    assign ins_valid   = ~q_empty;
    assign instruction = q_head.word;
    assign ins_pc      = q_head.pc;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            outstanding_d = outstanding_q - OW'(mem_rvalid);
            discard_d     = outstanding_q - OW'(mem_rvalid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd1;
            outstanding_d = outstanding_q + OW'(accept) - OW'(mem_rvalid);
            if (mem_rvalid && discard_q != '0) discard_d = discard_q - OW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_q         <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_ins_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (redirect),
        .push_i      (resp_keep),
        .push_data_i (q_push),
        .pop_i       (pop),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .count_o     (q_count)
    );

    // Holds only the addresses of live requests; stale ones are dropped by the flush.
    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_req_pc (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (redirect),
        .push_i      (accept),
        .push_data_i (fetch_pc_q),
        .pop_i       (resp_keep),
        .head_o      (req_pc),
        .empty_o     (pc_empty),
        .full_o      (pc_full),
        .count_o     (pc_count)
    );

    a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset_n)
        mem_rvalid |-> (outstanding_q != '0));
    a_pc_tracks_live: assert property (@(posedge clock) disable iff (!reset_n)
        OW'(pc_count) == live);
    a_pc_not_empty:   assert property (@(posedge clock) disable iff (!reset_n)
        resp_keep |-> !pc_empty);
    a_pc_not_full:    assert property (@(posedge clock) disable iff (!reset_n)
        accept |-> !pc_full);
    a_queue_room:     assert property (@(posedge clock) disable iff (!reset_n)
        resp_keep |-> (!q_full || pop));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench: in-order variable-latency memory model, directed scenarios, then random traffic.
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    logic        clock = 1'b0;
    logic        reset_n, mem_req, mem_ready, mem_rvalid, ins_valid, ins_ready, redirect;
    logic [31:0] mem_addr, mem_rdata, instruction, ins_pc, redirect_pc;

    memreq_t     pending[$];
    entry_t      expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0, lastDue = 0, latMin = 1, latMax = 1, nAccept = 0, nConsumed = 0;
    int          relCyc, firstReq, firstValid, validCount, base, redirCyc;
    logic        hit;
    logic [31:0] modelPc;
    logic        wantRstN, wantReady, wantMemReady, wantRedirect;
    logic [31:0] wantRedirectPc;
    logic        sMemReq, sInsValid;
    logic [31:0] sMemAddr, sInsPc;
    logic [31:0] wrapPcs [4];

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .instruction (instruction),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs and memory response, then let the models react to the DUT.
    task automatic applyStimulus();
        @(negedge clock);
        cyc++;
        reset_n     = wantRstN;
        redirect    = wantRedirect;
        redirect_pc = wantRedirectPc;
        ins_ready   = wantReady;
        mem_ready   = wantMemReady;
        mem_rvalid  = 1'b0;
        mem_rdata   = $urandom;
        if (!wantRstN) begin
            pending.delete();
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(pending[0].addr);
            void'(pending.pop_front());
        end
        #1;
        sMemReq   = mem_req;
        sMemAddr  = mem_addr;
        sInsValid = ins_valid;
        sInsPc    = ins_pc;
        if (!reset_n) begin
            expQ.delete();
            modelPc = RST_PC;
            lastDue = cyc;
        end else if (redirect) begin
            checkOutput("redirect_blocks_req", mem_req, 32'h0);
            expQ.delete();
            modelPc = redirect_pc;
        end else if (mem_req && mem_ready) begin
            int due;
            checkOutput("req_addr", mem_addr, modelPc);
            due = cyc + $urandom_range(latMax, latMin);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            pending.push_back('{addr: mem_addr, due: due});
            expQ.push_back('{word: memWord(modelPc), pc: modelPc});
            modelPc = modelPc + 32'd1;
            nAccept++;
        end
    endtask

    task automatic holdReset();
        wantRstN     = 1'b0;
        wantRedirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (i > 0) begin
                checkOutput("reset_req", sMemReq, 32'h0);
                checkOutput("reset_valid", sInsValid, 32'h0);
            end
        end
        wantRstN = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset_n === 1'b1 && ins_valid === 1'b1 && ins_ready === 1'b1 && redirect === 1'b0) begin
                nConsumed++;
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_ins: got pc %h, expected no instruction", ins_pc);
                end else begin
                    entry_t e;
                    e = expQ.pop_front();
                    checkOutput("ins_pc", ins_pc, e.pc);
                    checkOutput("instruction", instruction, e.word);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit, expected run to finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        wantRstN = 1'b0; wantReady = 1'b1; wantMemReady = 1'b1; wantRedirect = 1'b0;
        wantRedirectPc = '0; modelPc = RST_PC;
        wrapPcs[0] = 32'hFFFF_FFFE; wrapPcs[1] = 32'hFFFF_FFFF;
        wrapPcs[2] = 32'h0000_0000; wrapPcs[3] = 32'h0000_0001;

        // Release timing and steady one-per-cycle throughput with 1-cycle memory.
        latMin = 1; latMax = 1;
        holdReset();
        applyStimulus();
        relCyc = cyc;
        checkOutput("no_req_in_release_cycle", sMemReq, 32'h0);
        firstReq = -1; firstValid = -1; validCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (sMemReq && firstReq < 0) firstReq = cyc;
            if (sInsValid && firstValid < 0) firstValid = cyc;
            if (i >= 4 && sInsValid) validCount++;
        end
        checkOutput("first_req_cycle", firstReq, relCyc + 1);
        checkOutput("req_to_valid_latency", firstValid - firstReq, 2);
        checkOutput("steady_throughput", validCount, 8);

        // Core stalled: exactly DEPTH fetches, then issue resumes at the next address.
        wantReady = 1'b0;
        holdReset();
        base = nAccept;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("stall_accepts", nAccept - base, DEPTH);
        checkOutput("stall_no_req", sMemReq, 32'h0);
        checkOutput("stall_head_valid", sInsValid, 32'h1);
        checkOutput("stall_head_pc", sInsPc, RST_PC);
        wantReady = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("resume_req", sMemReq, 32'h1);
        checkOutput("resume_addr", sMemAddr, 32'd4);
        for (int i = 0; i < 2; i++) applyStimulus();

        // Latency 3, redirect with three requests in flight.
        latMin = 3; latMax = 3;
        holdReset();
        base = nAccept;
        for (int i = 0; i < 10 && (nAccept - base) < 3; i++) applyStimulus();
        checkOutput("inflight_before_redirect", nAccept - base, 3);
        wantRedirect = 1'b1; wantRedirectPc = 32'h40;
        applyStimulus();
        redirCyc = cyc;
        wantRedirect = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            applyStimulus();
            if (sInsValid) hit = 1'b1;
        end
        checkOutput("redirect_first_pc", sInsPc, 32'h40);
        checkOutput("redirect_latency", cyc - redirCyc, 5);

        // Redirect coinciding with a pop and a response, target near the address wrap.
        latMin = 1; latMax = 1;
        holdReset();
        for (int i = 0; i < 6; i++) applyStimulus();
        wantRedirect = 1'b1; wantRedirectPc = 32'hFFFF_FFFE;
        applyStimulus();
        wantRedirect = 1'b0;
        checkOutput("pre_redirect_head_valid", sInsValid, 32'h1);
        applyStimulus();
        checkOutput("flushed_after_redirect", sInsValid, 32'h0);
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("wrap_valid", sInsValid, 32'h1);
            checkOutput("wrap_pc", sInsPc, wrapPcs[k]);
        end

        // Reset mid-operation with buffered words and requests in flight.
        latMin = 2; latMax = 2; wantReady = 1'b0;
        holdReset();
        for (int i = 0; i < 6; i++) applyStimulus();
        wantRstN = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_clears_valid", sInsValid, 32'h0);
        checkOutput("reset_clears_req", sMemReq, 32'h0);
        wantRstN = 1'b1; wantReady = 1'b1; latMin = 1; latMax = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("restart_req", sMemReq, 32'h1);
        checkOutput("restart_addr", sMemAddr, RST_PC);

        // Random traffic: variable latency, backpressure on both sides, occasional redirects.
        latMin = 1; latMax = 4;
        holdReset();
        base = nConsumed;
        for (int i = 0; i < 2500; i++) begin
            wantReady      = ($urandom_range(3, 0) != 0);
            wantMemReady   = ($urandom_range(9, 0) < 7);
            wantRedirect   = ($urandom_range(31, 0) == 0);
            wantRedirectPc = ($urandom_range(2, 0) == 0) ? 32'hFFFF_FFFC + $urandom_range(3, 0) : $urandom;
            applyStimulus();
        end
        checkOutput("random_progress", (nConsumed - base) > 300, 32'h1);

        wantMemReady = 1'b0; wantReady = 1'b1; wantRedirect = 1'b0;
        for (int i = 0; i < 100 && (expQ.size() > 0 || pending.size() > 0); i++) begin
            applyStimulus();
            #2;
        end
        checkOutput("drain_empty", expQ.size(), 32'h0);
        applyStimulus();
        checkOutput("drain_no_valid", sInsValid, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch stage that sits directly upstream of the single-cycle MIPS core. It generates word addresses into instruction memory and tolerates variable, in-order memory latency. Returned words are buffered in a small FIFO and handed to the core with a valid/ready handshake. Jumps, jump-register and taken branches reach the block as a redirect, which flushes the queue and discards stale in-flight responses.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0: first fetch address after reset (word address).
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `mem_req` out 1: request valid this cycle.
- `mem_addr` out 32: word address of request (= `fetch_pc`).
- `mem_ready` in 1: memory accepts request this cycle.
- `mem_rvalid` in 1: response valid; responses return in request order, ≥1 cycle after acceptance.
- `mem_rdata` in 32: instruction word.
- `ins_valid` out 1: queue head valid.
- `instruction` out 32: head word.
- `ins_pc` out 32: address of head word.
- `ins_ready` in 1: core consumes head this cycle.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch address.

## Operation
- State: `fetch_pc` (32), queue storage {word, pc} × DEPTH, `rd_ptr`/`wr_ptr` (log2 DEPTH, wrap mod DEPTH), `count` (0..DEPTH), `outstanding` (0..2·DEPTH−1), `discard` (≤ `outstanding`).
- Reset: `fetch_pc`=RESET_PC, pointers/count/outstanding/discard=0; hence `mem_req`=0 during reset, `ins_valid`=0, `instruction`/`ins_pc` don't-care.
- Issue: `mem_req` = ~`redirect` & (`count` + (`outstanding` − `discard`) < DEPTH) & (`outstanding` < 2·DEPTH−1). Accept = `mem_req` & `mem_ready` → `fetch_pc` += 1 (wraps 32'hFFFFFFFF→0), `outstanding` += 1. A request PC FIFO (DEPTH entries) records the issued address.
- Response: on `mem_rvalid`, `outstanding` −= 1. If `discard`>0 → drop, `discard` −= 1; else write {`mem_rdata`, recorded pc} at `wr_ptr`.
- Pop: `ins_valid` & `ins_ready` → `rd_ptr`++, `count`−=1. Simultaneous write and pop on a full or empty queue is legal; `count` stays consistent.
- Redirect (highest priority): `fetch_pc` := `redirect_pc`; queue emptied; same-cycle pop and same-cycle response both ignored/dropped; `discard` := `outstanding` − `mem_rvalid` (all remaining in-flight responses are stale); no request issued that cycle.
- `mem_rvalid` with `outstanding`=0 is a protocol error; simulation assertion.

## Timing
- Outputs `ins_valid`/`instruction`/`ins_pc` come from registers/head of the FIFO; `mem_req`/`mem_addr` are combinational from state and `redirect`.
- 1-cycle memory: request accepted in cycle t, `mem_rvalid` in t+1, `ins_valid` in t+2.
- First request after reset release: the cycle after the first edge with `reset_n`=1.
- Redirect in cycle t: first request with `redirect_pc` in t+1; with 1-cycle memory, the new instruction is valid in t+3.
- Steady state with `ins_ready`=1 and 1-cycle memory: one instruction per cycle.
- Reset asserted mid-operation: all state is cleared at the next edge; any later responses arriving while `outstanding`=0 are outside the protocol, since memory must be reset together with the block.

## Structure
- Shared package/header: `RESET_PC` default and a pc+word entry width constant, so the core and memory models can share them.
- One natural sub-module: `sync_fifo` (parameterised width/depth, registered pointers, count). It is instantiated twice: once for the instruction queue (64-bit entries) and once for the request PC FIFO (32-bit entries).

## Test plan
- Reset release, memory latency 1, `ins_ready`=1 → PCs 0,1,2,3… presented one per cycle; first `ins_valid` 2 cycles after first `mem_req`.
- `ins_ready`=0 → exactly DEPTH=4 requests (addr 0..3), then `mem_req`=0; `count`=4. Raising `ins_ready` resumes issue at addr 4.
- Latency 3 with a redirect to 32'h40 while 3 requests are in flight → the 3 stale responses are dropped; the next valid `ins_pc` is 32'h40.
- Redirect in the same cycle as a pop and an `mem_rvalid` → neither is applied, queue empty, `discard` = outstanding−1.
- Redirect to 32'hFFFFFFFE → fetches FFFFFFFE, FFFFFFFF, 0, 1 in order.
- `reset_n` low while queue full with 2 outstanding → the next cycle shows `ins_valid`=0, `mem_req`=0; after release, fetch restarts at RESET_PC.
